seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 260 ++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Sequential ALU with an IDLE -> EXEC -> DONE handshake.
//             Single-cycle ops: ADD, SUB, AND, CMP.
//             Iterative ops:    SRL, SLL, SRA shift one bit per EXEC cycle.
//                               MUL is a W-cycle shift-add.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock; all state changes on the rising edge
//    rst_n          in   asynchronous active-low reset
//    start          in   request an operation; sampled only in IDLE
//    op             in   opcode, sampled with start
//    ra_in, rb_in   in   operands, sampled with start
//    busy           out  high while the FSM is in EXEC
//    done           out  single-cycle pulse while the FSM is in DONE
//    res_out        out  result word (low half of the product for MUL)
//    car_out        out  carry/borrow/shift-out bit, or high half of product
//    zero           out  res_out == 0
//    jump           out  CMP found equal operands
// ============================================================================
module seq_alu #(
    parameter int REG_WIDTH = 8,
    parameter int OP_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic [REG_WIDTH-1:0] ra_in,
    input  logic [REG_WIDTH-1:0] rb_in,
    output logic                 busy,
    output logic                 done,
    output logic [REG_WIDTH-1:0] res_out,
    output logic [REG_WIDTH-1:0] car_out,
    output logic                 zero,
    output logic                 jump
);

    // Counter must be able to hold W itself (the clamped shift count).
    localparam int CW = $clog2(REG_WIDTH + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_CMP = OP_WIDTH'(7);

    localparam logic [CW-1:0]        CNT_W   = CW'(REG_WIDTH);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [REG_WIDTH:0]   W_EXT   = (REG_WIDTH + 1)'(REG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [OP_WIDTH-1:0]    op_q;
    logic [REG_WIDTH-1:0]   a_q;     // operand A / multiplicand
    logic [REG_WIDTH-1:0]   b_q;     // operand B / multiplier, then product low half
    logic [REG_WIDTH-1:0]   w_q;     // shift value, or product high half
    logic                   c_q;     // last bit shifted out
    logic [CW-1:0]          cnt_q;   // remaining EXEC iterations
    logic                   busy_q;
    logic                   done_q;
    logic [REG_WIDTH-1:0]   res_q;
    logic [REG_WIDTH-1:0]   car_q;
    logic                   zero_q;
    logic                   jump_q;

    // ------------------------------------------------------------------
    // Iteration count loaded at start: clamped shift amount, W for MUL,
    // otherwise a single EXEC cycle.
    // ------------------------------------------------------------------
    logic          is_shift_in;
    logic [CW-1:0] cnt_load;

    always_comb begin
        is_shift_in = (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
        cnt_load    = CNT_ONE;
        if (is_shift_in) begin
            if ({1'b0, rb_in} >= W_EXT) begin
                cnt_load = CNT_W;
            end else begin
                cnt_load = CW'(rb_in);
            end
        end else if (op == OP_MUL) begin
            cnt_load = CNT_W;
        end
    end

    // ------------------------------------------------------------------
    // One EXEC iteration. A zero shift count leaves the value untouched,
    // which gives the "n=0 returns ra" behaviour with a single EXEC cycle.
    // MUL adds the multiplicand into the high half when the multiplier LSB
    // is set, then shifts the {carry, high, low} triple right by one.
    // ------------------------------------------------------------------
    logic [REG_WIDTH:0]   mul_sum;
    logic [REG_WIDTH-1:0] step_w;
    logic [REG_WIDTH-1:0] step_b;
    logic                 step_c;

    always_comb begin
        mul_sum = {1'b0, w_q} + (b_q[0] ? {1'b0, a_q} : {(REG_WIDTH + 1){1'b0}});
        step_w  = w_q;
        step_b  = b_q;
        step_c  = c_q;
        case (op_q)
            OP_SRL: begin
                if (cnt_q != '0) begin
                    step_w = w_q >> 1;
                    step_c = w_q[0];
                end
            end
            OP_SLL: begin
                if (cnt_q != '0) begin
                    step_w = w_q << 1;
                    step_c = w_q[REG_WIDTH-1];
                end
            end
            OP_SRA: begin
                if (cnt_q != '0) begin
                    step_w = $signed(w_q) >>> 1;
                    step_c = w_q[0];
                end
            end
            OP_MUL: begin
                step_w = mul_sum[REG_WIDTH:1];
                step_b = {mul_sum[0], b_q[REG_WIDTH-1:1]};
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Final result, evaluated during the last EXEC cycle and captured on
    // the transition into DONE.
    // ------------------------------------------------------------------
    logic [REG_WIDTH:0]   add_sum;
    logic [REG_WIDTH-1:0] diff;
    logic [REG_WIDTH-1:0] res_d;
    logic [REG_WIDTH-1:0] car_d;
    logic                 jump_d;

    always_comb begin
        add_sum = {1'b0, a_q} + {1'b0, b_q};
        diff    = a_q - b_q;
        res_d   = '0;
        car_d   = '0;
        jump_d  = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_d = add_sum[REG_WIDTH-1:0];
                car_d = {{(REG_WIDTH-1){1'b0}}, add_sum[REG_WIDTH]};
            end
            OP_SUB: begin
                res_d = diff;
                car_d = {{(REG_WIDTH-1){1'b0}}, (a_q < b_q)};
            end
            OP_AND: begin
                res_d = a_q & b_q;
            end
            OP_SRL, OP_SLL, OP_SRA: begin
                res_d = step_w;
                car_d = {{(REG_WIDTH-1){1'b0}}, step_c};
            end
            OP_MUL: begin
                res_d = step_b;
                car_d = step_w;
            end
            OP_CMP: begin
                res_d  = diff;
                jump_d = (a_q == b_q);
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            car_q   <= '0;
            zero_q  <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= ra_in;
                        b_q     <= rb_in;
                        // Product high half starts cleared; shifts work on ra.
                        w_q     <= (op == OP_MUL) ? '0 : ra_in;
                        c_q     <= 1'b0;
                        cnt_q   <= cnt_load;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    w_q <= step_w;
                    b_q <= step_b;
                    c_q <= step_c;
                    if (cnt_q > CNT_ONE) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= res_d;
                        car_q   <= car_d;
                        zero_q  <= (res_d == '0);
                        jump_q  <= jump_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A start seen here is dropped, not queued.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign res_out = res_q;
    assign car_out = car_q;
    assign zero    = zero_q;
    assign jump    = jump_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Directed self-checking bench for seq_alu (W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op    = 3'd0;
    logic [7:0] ra    = 8'h00;
    logic [7:0] rb    = 8'h00;

    logic       busy;
    logic       done;
    logic [7:0] res_out;
    logic [7:0] car_out;
    logic       zero;
    logic       jump;

    int total = 0;
    int bad   = 0;
    int lat;

    seq_alu #(
        .REG_WIDTH (8),
        .OP_WIDTH  (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .ra_in   (ra),
        .rb_in   (rb),
        .busy    (busy),
        .done    (done),
        .res_out (res_out),
        .car_out (car_out),
        .zero    (zero),
        .jump    (jump)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Launch one op and count rising edges after the start edge until done.
    task automatic run(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input string tag, output int latency);
        @(negedge clk);
        op = o; ra = a; rb = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
        latency = 0;
        while (done !== 1'b1 && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic check_op(input string tag, input logic [2:0] o,
                            input logic [7:0] a, input logic [7:0] b,
                            input int exp_lat, input logic [7:0] exp_res,
                            input logic [7:0] exp_car, input logic exp_zero,
                            input logic exp_jump);
        int l;
        run(o, a, b, tag, l);
        chk({tag, "_lat"},  16'(l), 16'(exp_lat));
        chk({tag, "_res"},  {8'd0, res_out}, {8'd0, exp_res});
        chk({tag, "_car"},  {8'd0, car_out}, {8'd0, exp_car});
        chk({tag, "_zero"}, {15'd0, zero}, {15'd0, exp_zero});
        chk({tag, "_jump"}, {15'd0, jump}, {15'd0, exp_jump});
        chk({tag, "_busy_done"}, {15'd0, busy}, 16'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_res",  {8'd0, res_out}, 16'd0);
        chk("rst_car",  {8'd0, car_out}, 16'd0);
        chk("rst_zero", {15'd0, zero}, 16'd0);
        chk("rst_jump", {15'd0, jump}, 16'd0);
        rst_n = 1'b1;

        // ---- directed ops (first one starts right after reset release) ----
        check_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h01, 1'b1, 1'b0);
        check_op("sub_01_02", 3'd1, 8'h01, 8'h02, 1, 8'hFF, 8'h01, 1'b0, 1'b0);
        check_op("sub_05_03", 3'd1, 8'h05, 8'h03, 1, 8'h02, 8'h00, 1'b0, 1'b0);
        check_op("and_f0_3c", 3'd2, 8'hF0, 8'h3C, 1, 8'h30, 8'h00, 1'b0, 1'b0);
        check_op("and_zero",  3'd2, 8'hF0, 8'h0F, 1, 8'h00, 8'h00, 1'b1, 1'b0);
        check_op("srl_f0_3",  3'd3, 8'hF0, 8'd3,  3, 8'h1E, 8'h00, 1'b0, 1'b0);
        check_op("srl_f0_5",  3'd3, 8'hF0, 8'd5,  5, 8'h07, 8'h01, 1'b0, 1'b0);
        check_op("srl_f0_0",  3'd3, 8'hF0, 8'd0,  1, 8'hF0, 8'h00, 1'b0, 1'b0);
        check_op("sll_81_1",  3'd4, 8'h81, 8'd1,  1, 8'h02, 8'h01, 1'b0, 1'b0);
        check_op("sra_80_9",  3'd5, 8'h80, 8'd9,  8, 8'hFF, 8'h01, 1'b0, 1'b0);
        check_op("mul_0f_11", 3'd6, 8'h0F, 8'h11, 8, 8'hFF, 8'h00, 1'b0, 1'b0);
        check_op("mul_ff_ff", 3'd6, 8'hFF, 8'hFF, 8, 8'h01, 8'hFE, 1'b0, 1'b0);
        check_op("cmp_eq",    3'd7, 8'h5A, 8'h5A, 1, 8'h00, 8'h00, 1'b1, 1'b1);
        check_op("cmp_ne",    3'd7, 8'h5A, 8'h5B, 1, 8'hFF, 8'h00, 1'b0, 1'b0);

        // ---- results hold while idle ----
        repeat (3) @(posedge clk);
        #1;
        chk("hold_res", {8'd0, res_out}, 16'h00FF);
        chk("hold_car", {8'd0, car_out}, 16'h0000);

        // ---- start pulsed mid-MUL is ignored ----
        @(negedge clk);
        op = 3'd6; ra = 8'h03; rb = 8'h05; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        repeat (2) begin
            @(posedge clk);
            #1 lat++;
        end
        @(negedge clk);
        op = 3'd0; ra = 8'hFF; rb = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("mulbusy_lat", 16'(lat), 16'd8);
        chk("mulbusy_res", {8'd0, res_out}, 16'h000F);
        chk("mulbusy_car", {8'd0, car_out}, 16'h0000);

        // ---- start raised during the DONE cycle is dropped ----
        start = 1'b1; op = 3'd0; ra = 8'h01; rb = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        chk("donestart_busy", {15'd0, busy}, 16'd0);
        @(posedge clk);
        #1;
        chk("donestart_busy2", {15'd0, busy}, 16'd0);
        chk("donestart_res",   {8'd0, res_out}, 16'h000F);

        // ---- asynchronous reset mid-MUL ----
        @(negedge clk);
        op = 3'd6; ra = 8'hFF; rb = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_done", {15'd0, done}, 16'd0);
        chk("midrst_res",  {8'd0, res_out}, 16'd0);
        chk("midrst_car",  {8'd0, car_out}, 16'd0);
        chk("midrst_zero", {15'd0, zero}, 16'd0);
        chk("midrst_jump", {15'd0, jump}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_op("post_rst_mul", 3'd6, 8'h0F, 8'h11, 8, 8'hFF, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
